// File: rtl/qsq_lut_product.sv
// Quarter-square multiplier back end: |s|, |d| -> ROM lookup of floor(k^2/4) -> difference.
// Three enabled pipeline stages; en=0 freezes every register including the valid chain.
module qsq_lut_product #(
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic signed [DATA_W:0]     i1,
  input  logic signed [DATA_W:0]     i2,
  output logic signed [2*DATA_W-1:0] product,
  output logic                       out_valid
);

  localparam int IW    = DATA_W + 1;
  localparam int QW    = 2 * DATA_W - 1;
  localparam int PW    = 2 * DATA_W;
  localparam int DEPTH = 2 ** DATA_W + 1;

  // Negation stays in IW unsigned bits so |-2^DATA_W| = 2^DATA_W without overflow.
  function automatic logic [IW-1:0] abs_u(input logic [IW-1:0] x);
    return x[IW-1] ? (~x + IW'(1)) : x;
  endfunction

  logic          v1, v2;
  logic [IW-1:0] m1, m2;
  logic [QW-1:0] q1, q2;

  // Quarter-square table Q[k] = floor(k^2/4), fixed at elaboration.
  logic [QW-1:0] qsq_rom [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign qsq_rom[k] = QW'((k * k) / 4);
  end

  // NOTE: non-blocking assignments in every clocked block so all stages sample
  // the pre-edge values of the previous stage, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // Stage 1: magnitudes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= '0;
      m2 <= '0;
    end else if (en && in_valid) begin
      m1 <= abs_u(i1);
      m2 <= abs_u(i2);
    end
  end

  // Stage 2: two synchronous read ports on the one table.
  // NOTE: the table itself is constant and needs no reset; only the read
  // registers clear so the pipeline comes out of reset at a known zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q2 <= '0;
    end else if (en && v1) begin
      q1 <= qsq_rom[m1];
      q2 <= qsq_rom[m2];
    end
  end

  // Stage 3: zero-extend both quarter squares and subtract as signed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if (en && v2) begin
      product <= $signed(PW'(q1)) - $signed(PW'(q2));
    end
  end

endmodule

// File: tb/tb_qsq_lut_product.sv
// Directed and exhaustive checks for qsq_lut_product (DATA_W = 8).
module tb_qsq_lut_product;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               in_valid;
  logic signed [8:0]  i1;
  logic signed [8:0]  i2;
  logic signed [15:0] product;
  logic               out_valid;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  qsq_lut_product #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .i1       (i1),
    .i2       (i2),
    .product  (product),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b);
    in_valid = 1'b1;
    i1       = 9'(a + b);
    i2       = 9'(a - b);
  endtask

  int exp_q[$];
  int n_out;
  int a_idx;
  int b_idx;
  bit ev;
  bit iv;
  int got;

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; i1 = '0; i2 = '0;
    tick(); tick();
    check("rst_product", product, 0);
    check("rst_valid", out_valid, 0);
    rst_n = 1'b1; en = 1'b1;

    // Single pair 3*5.
    drive(3, 5);
    tick();
    in_valid = 1'b0;
    tick();
    check("lat_early", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_product", product, 15);
    tick();
    check("lat_valid_drop", out_valid, 0);
    check("lat_hold", product, 15);

    // Corners streamed back-to-back.
    drive(-128, -128); tick();
    drive(-128, 127);  tick();
    drive(127, 127);   tick();
    check("c0_valid", out_valid, 1);
    check("c0_product", product, 16384);
    drive(0, 0);       tick();
    check("c1_valid", out_valid, 1);
    check("c1_product", product, -16256);
    in_valid = 1'b0;   tick();
    check("c2_valid", out_valid, 1);
    check("c2_product", product, 16129);
    tick();
    check("c3_valid", out_valid, 1);
    check("c3_product", product, 0);
    tick();
    check("c_end_valid", out_valid, 0);

    // Five pairs with a two-cycle stall after the second.
    drive(2, 3);   tick();
    drive(-4, 7);  tick();
    en = 1'b0;
    drive(10, 10); tick();
    check("st_hold0", out_valid, 0);
    tick();
    check("st_hold1", out_valid, 0);
    check("st_hold_prod", product, 0);
    en = 1'b1;     tick();
    check("st0_valid", out_valid, 1);
    check("st0_product", product, 6);
    drive(-5, -6); tick();
    check("st1_valid", out_valid, 1);
    check("st1_product", product, -28);
    drive(100, -2); tick();
    check("st2_valid", out_valid, 1);
    check("st2_product", product, 100);
    in_valid = 1'b0; tick();
    check("st3_valid", out_valid, 1);
    check("st3_product", product, 30);
    tick();
    check("st4_valid", out_valid, 1);
    check("st4_product", product, -200);
    tick();
    check("st_end_valid", out_valid, 0);
    check("st_end_hold", product, -200);

    // Valid, gap, valid.
    drive(3, 5);   tick();
    in_valid = 1'b0; tick();
    drive(-7, 9);  tick();
    check("gap0_valid", out_valid, 1);
    check("gap0_product", product, 15);
    in_valid = 1'b0; tick();
    check("gap1_valid", out_valid, 0);
    check("gap1_hold", product, 15);
    tick();
    check("gap2_valid", out_valid, 1);
    check("gap2_product", product, -63);
    tick();
    check("gap3_valid", out_valid, 0);

    // Reset with the pipeline full.
    drive(11, 13); tick();
    drive(-9, 4);  tick();
    drive(6, -6);  tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_product", product, 0);
    check("mid_rst_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_valid", out_valid, 0);
    end
    check("post_rst_product", product, 0);

    // Exhaustive with random stalls; model is plain multiplication.
    n_out = 0;
    a_idx = -128;
    b_idx = -128;
    for (int cyc = 0; cyc < 80000 && (a_idx < 128 || exp_q.size() > 0); cyc++) begin
      ev = ($urandom_range(15) != 0);
      iv = (a_idx < 128);
      en = ev;
      if (iv) drive(a_idx, b_idx);
      else    in_valid = 1'b0;
      tick();
      if (ev && iv) begin
        exp_q.push_back(a_idx * b_idx);
        if (b_idx == 127) begin
          b_idx = -128;
          a_idx++;
        end else begin
          b_idx++;
        end
      end
      if (ev && out_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("ex_spurious_valid", 1, 0);
        end else begin
          got = exp_q.pop_front();
          check("ex_product", product, got);
        end
      end
    end
    in_valid = 1'b0;
    en = 1'b1;
    tick(); tick(); tick();
    check("ex_out_count", n_out, 65536);
    check("ex_pending", exp_q.size(), 0);
    check("ex_tail_valid", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
